// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM pipeline stage: payload struct and skid-buffer state encoding.
package pipe_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] pc_plus4;
        logic              reg_write;
        logic [1:0]        result_src;
        logic              mem_write;
    } ex_mem_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer with synchronous flush; head entry is always in main_q.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire_s, out_fire_s;

    assign in_fire_s  = valid_i && ready_o;
    assign out_fire_s = valid_o && ready_i;
    assign data_o     = main_q;

    // State and entry registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next state and entry movement; flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_d = ONE;
                        main_d  = data_i;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        state_d = ONE;
                        main_d  = data_i;
                    end else if (in_fire_s) begin
                        state_d = TWO;
                        skid_d  = data_i;
                    end else if (out_fire_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decoded from registered state only.
    always_comb begin
        ready_o = 1'b1;
        valid_o = 1'b0;
        case (state_q)
            EMPTY: begin
                ready_o = 1'b1;
                valid_o = 1'b0;
            end
            ONE: begin
                ready_o = 1'b1;
                valid_o = 1'b1;
            end
            TWO: begin
                ready_o = 1'b0;
                valid_o = 1'b1;
            end
            default: begin
                ready_o = 1'b1;
                valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: skid-buffered payload with control squashing.
// Optional stall counter output enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      valid_e_i,
    output logic                      ready_e_o,
    input  logic [DATA_WIDTH-1:0]     alu_result_e_i,
    input  logic [DATA_WIDTH-1:0]     write_data_e_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_e_i,
    input  logic [ADDRESS_WIDTH-1:0]  pc_plus4_e_i,
    input  logic                      reg_write_e_i,
    input  logic [1:0]                result_src_e_i,
    input  logic                      mem_write_e_i,
    output logic                      valid_m_o,
    input  logic                      ready_m_i,
    output logic [DATA_WIDTH-1:0]     alu_result_m_o,
    output logic [DATA_WIDTH-1:0]     write_data_m_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_m_o,
    output logic [ADDRESS_WIDTH-1:0]  pc_plus4_m_o,
    output logic                      reg_write_m_o,
    output logic [1:0]                result_src_m_o,
    output logic                      mem_write_m_o
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    ex_mem_t pay_in_s;
    ex_mem_t pay_out_s;
    logic    valid_s;

    assign pay_in_s.alu_result = alu_result_e_i;
    assign pay_in_s.write_data = write_data_e_i;
    assign pay_in_s.rd         = rd_e_i;
    assign pay_in_s.pc_plus4   = pc_plus4_e_i;
    assign pay_in_s.reg_write  = reg_write_e_i;
    assign pay_in_s.result_src = result_src_e_i;
    assign pay_in_s.mem_write  = mem_write_e_i;

    pipe_skid_buf #(
        .WIDTH ($bits(ex_mem_t))
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_e_i),
        .ready_o (ready_e_o),
        .data_i  (pay_in_s),
        .valid_o (valid_s),
        .ready_i (ready_m_i),
        .data_o  (pay_out_s)
    );

    assign valid_m_o      = valid_s;
    assign alu_result_m_o = pay_out_s.alu_result;
    assign write_data_m_o = pay_out_s.write_data;
    assign rd_m_o         = pay_out_s.rd;
    assign pc_plus4_m_o   = pay_out_s.pc_plus4;
    assign result_src_m_o = pay_out_s.result_src;
    // A stale head must never write the register file or memory.
    assign reg_write_m_o  = pay_out_s.reg_write && valid_s;
    assign mem_write_m_o  = pay_out_s.mem_write && valid_s;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the head waits on the memory stage.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (valid_s && !ready_m_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized and directed bench for ex_mem_stage against a queue-based reference model.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, valid_e_i, ready_e_o, ready_m_i, valid_m_o;
    logic [31:0] alu_result_e_i, write_data_e_i, pc_plus4_e_i;
    logic [4:0]  rd_e_i;
    logic        reg_write_e_i, mem_write_e_i;
    logic [1:0]  result_src_e_i;
    logic [31:0] alu_result_m_o, write_data_m_o, pc_plus4_m_o;
    logic [4:0]  rd_m_o;
    logic        reg_write_m_o, mem_write_m_o;
    logic [1:0]  result_src_m_o;
`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    ent_t        mq[$];
    ent_t        last_head;
    logic [31:0] m_stall;
    logic [31:0] drained[$];

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .valid_e_i      (valid_e_i),
        .ready_e_o      (ready_e_o),
        .alu_result_e_i (alu_result_e_i),
        .write_data_e_i (write_data_e_i),
        .rd_e_i         (rd_e_i),
        .pc_plus4_e_i   (pc_plus4_e_i),
        .reg_write_e_i  (reg_write_e_i),
        .result_src_e_i (result_src_e_i),
        .mem_write_e_i  (mem_write_e_i),
        .valid_m_o      (valid_m_o),
        .ready_m_i      (ready_m_i),
        .alu_result_m_o (alu_result_m_o),
        .write_data_m_o (write_data_m_o),
        .rd_m_o         (rd_m_o),
        .pc_plus4_m_o   (pc_plus4_m_o),
        .reg_write_m_o  (reg_write_m_o),
        .result_src_m_o (result_src_m_o),
        .mem_write_m_o  (mem_write_m_o)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        last_head = '0;
        m_stall = 32'd0;
    endfunction

    // Model of one clock edge: FIFO of depth 2, flush wins, data holds after drain.
    function automatic void model_step();
        int   n;
        bit   pop;
        bit   push;
        ent_t e;
        n = mq.size();
        pop = (n > 0) && ready_m_i;
        push = valid_e_i && (n < 2);
        e = '{alu_result_e_i, write_data_e_i, rd_e_i, pc_plus4_e_i,
              reg_write_e_i, result_src_e_i, mem_write_e_i};
        if (n > 0 && !ready_m_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        if (pop) drained.push_back(mq[0].alu);
        if (flush_i) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        if (mq.size() > 0) last_head = mq[0];
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] alu);
        valid_e_i      = v;
        alu_result_e_i = alu;
        write_data_e_i = $urandom;
        rd_e_i         = 5'($urandom);
        pc_plus4_e_i   = $urandom;
        reg_write_e_i  = 1'($urandom);
        result_src_e_i = 2'($urandom);
        mem_write_e_i  = 1'($urandom);
    endtask

    task automatic chk_drained(input string nm, input int first, input int cnt);
        chk({nm, "_count"}, 64'(drained.size()), 64'(cnt));
        for (int k = 0; k < cnt && k < drained.size(); k++)
            chk(nm, 64'(drained[k]), 64'(first + k));
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    initial begin
        ent_t h;
        bit   v;
        forever begin
            @(negedge clk);
            v = mq.size() > 0;
            h = v ? mq[0] : last_head;
            chk("valid_m", 64'(valid_m_o), 64'(v));
            chk("ready_e", 64'(ready_e_o), 64'(mq.size() < 2));
            chk("alu_m", 64'(alu_result_m_o), 64'(h.alu));
            chk("wdata_m", 64'(write_data_m_o), 64'(h.wd));
            chk("rd_m", 64'(rd_m_o), 64'(h.rd));
            chk("pc4_m", 64'(pc_plus4_m_o), 64'(h.pc));
            chk("rsrc_m", 64'(result_src_m_o), 64'(h.rs));
            chk("regw_m", 64'(reg_write_m_o), 64'(v && h.rw));
            chk("memw_m", 64'(mem_write_m_o), 64'(v && h.mw));
`ifdef EX_MEM_STALL_CNT_EN
            chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
`endif
        end
    end

    initial begin
        int          i;
        int          guard;
        bit          saw_not_ready;
        bit          acc;
        logic [31:0] stall_base;
        rst_i = 1'b1;
        flush_i = 1'b0;
        ready_m_i = 1'b1;
        set_in(1'b0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("rst_ready_e", 64'(ready_e_o), 64'd1);
        chk("rst_valid_m", 64'(valid_m_o), 64'd0);
        chk("rst_alu_m", 64'(alu_result_m_o), 64'd0);

        // Streaming 1..8 with 1-cycle latency.
        drained.delete();
        for (int k = 1; k <= 8; k++) begin
            set_in(1'b1, 32'(k));
            cyc();
            chk("stream_latency", 64'(alu_result_m_o), 64'(k));
        end
        set_in(1'b0, 32'd0);
        repeat (3) cyc();
        chk_drained("stream_order", 1, 8);

        // Single-cycle back-pressure mid-stream.
        drained.delete();
        i = 1;
        guard = 0;
        saw_not_ready = 1'b0;
        while (i <= 8 && guard < 40) begin
            set_in(1'b1, 32'(i));
            ready_m_i = (guard == 3) ? 1'b0 : 1'b1;
            acc = ready_e_o;
            cyc();
            if (guard == 3) begin
                saw_not_ready = !ready_e_o;
            end
            if (acc) i++;
            guard++;
        end
        chk("bp_completed", 64'(i), 64'd9);
        chk("bp_ready_fell", 64'(saw_not_ready), 64'd1);
        set_in(1'b0, 32'd0);
        ready_m_i = 1'b1;
        repeat (4) cyc();
        chk_drained("bp_order", 1, 8);

        // Long stall: exactly two entries held.
`ifdef EX_MEM_STALL_CNT_EN
        stall_base = stall_cnt_o;
`else
        stall_base = 32'd0;
`endif
        ready_m_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_in(1'b1, 32'(11 + k));
            cyc();
        end
        chk("hold_valid", 64'(valid_m_o), 64'd1);
        chk("hold_ready_e", 64'(ready_e_o), 64'd0);
        chk("hold_head", 64'(alu_result_m_o), 64'd11);
        chk("hold_model_depth", 64'(mq.size()), 64'd2);
`ifdef EX_MEM_STALL_CNT_EN
        chk("stall_five", 64'(stall_cnt_o - stall_base), 64'd5);
`endif

        // Flush with concurrent input while full.
        flush_i = 1'b1;
        ready_m_i = 1'b1;
        set_in(1'b1, 32'd99);
        reg_write_e_i = 1'b1;
        mem_write_e_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("flush_valid", 64'(valid_m_o), 64'd0);
        chk("flush_ready_e", 64'(ready_e_o), 64'd1);
        chk("flush_regw", 64'(reg_write_m_o), 64'd0);
        chk("flush_memw", 64'(mem_write_m_o), 64'd0);
        set_in(1'b0, 32'd0);
        cyc();
        chk("flush_dropped", 64'(valid_m_o), 64'd0);
`ifdef EX_MEM_STALL_CNT_EN
        chk("stall_after_flush", 64'(stall_cnt_o - stall_base), 64'd5);
`endif

        // Squash: control drops after drain, data holds.
        set_in(1'b1, 32'd77);
        reg_write_e_i = 1'b1;
        mem_write_e_i = 1'b1;
        cyc();
        chk("sq_regw_live", 64'(reg_write_m_o), 64'd1);
        chk("sq_memw_live", 64'(mem_write_m_o), 64'd1);
        set_in(1'b0, 32'd0);
        cyc();
        chk("sq_valid", 64'(valid_m_o), 64'd0);
        chk("sq_regw", 64'(reg_write_m_o), 64'd0);
        chk("sq_memw", 64'(mem_write_m_o), 64'd0);
        chk("sq_alu_hold", 64'(alu_result_m_o), 64'd77);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            set_in(1'($urandom_range(0, 3) != 0), $urandom);
            ready_m_i = ($urandom_range(0, 9) < 7);
            flush_i = ($urandom_range(0, 19) == 0);
            cyc();
        end
        flush_i = 1'b0;

        // Asynchronous reset with two entries held.
        ready_m_i = 1'b0;
        set_in(1'b1, 32'd201);
        cyc();
        set_in(1'b1, 32'd202);
        cyc();
        chk("pre_rst_full", 64'(ready_e_o), 64'd0);
        #2 rst_i = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 64'(valid_m_o), 64'd0);
        chk("arst_ready_e", 64'(ready_e_o), 64'd1);
        chk("arst_alu", 64'(alu_result_m_o), 64'd0);
        chk("arst_regw", 64'(reg_write_m_o), 64'd0);
        chk("arst_memw", 64'(mem_write_m_o), 64'd0);
`ifdef EX_MEM_STALL_CNT_EN
        chk("arst_stall", 64'(stall_cnt_o), 64'd0);
`endif
        @(posedge clk);
        #1 rst_i = 1'b0;
        set_in(1'b0, 32'd0);
        ready_m_i = 1'b1;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised execute-to-memory pipeline stage. It replaces the plain EX/MEM flip-flop bank with a two-entry skid buffer that supports a valid/ready handshake, back-pressure from the memory stage, and synchronous flush. Control fields are squashed automatically whenever the stage holds no valid instruction. It sits between the ALU/execute stage and the data-memory stage of the pipelined core.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, width of PC values
- DATA_WIDTH, 32, width of ALU result and store data
- REG_ADDR_WIDTH, 5, width of destination register index

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous flush of both entries
- valid_e_i  in  1  execute stage presents an instruction
- ready_e_o  out  1  stage can accept an instruction this cycle
- alu_result_e_i  in  DATA_WIDTH  ALU output
- write_data_e_i  in  DATA_WIDTH  store data (full width)
- rd_e_i  in  REG_ADDR_WIDTH  destination register
- pc_plus4_e_i  in  ADDRESS_WIDTH  PC+4
- reg_write_e_i  in  1  register-file write enable
- result_src_e_i  in  2  writeback mux select
- mem_write_e_i  in  1  data-memory write enable
- valid_m_o  out  1  output entry valid
- ready_m_i  in  1  memory stage accepts the output entry
- alu_result_m_o, write_data_m_o, rd_m_o, pc_plus4_m_o, reg_write_m_o, result_src_m_o, mem_write_m_o  out  matching widths  registered copies of the head entry

## Operation
- Transfer in: valid_e_i && ready_e_o at the clock edge. Transfer out: valid_m_o && ready_m_i at the clock edge.
- States: EMPTY (0 entries), ONE (main register holds the head), TWO (main plus skid).
- EMPTY: on transfer in -> ONE.
- ONE: in only -> TWO (new entry goes to skid). Out only -> EMPTY. In and out together -> ONE (new entry goes to main).
- TWO: on transfer out -> ONE (skid moves to main). Transfer in is impossible because ready_e_o=0.
- ready_e_o = (state != TWO). It is decoded from registered state only, with no combinational path from ready_m_i.
- valid_m_o = (state != EMPTY).
- reg_write_m_o and mem_write_m_o are forced to 0 whenever valid_m_o=0. Data outputs hold their last values.
- flush_i: next state is EMPTY and all entries are invalidated. Flush has priority over any simultaneous transfer in or out, and an accepted-but-flushed input is dropped.
- Payload is captured unmodified, with no width conversion.

## Timing
- Reset: state EMPTY. All data outputs are 0, valid_m_o=0, reg_write_m_o=0, mem_write_m_o=0, ready_e_o=1. Reset takes effect immediately, mid-operation, and discards both entries.
- Latency: 1 cycle. An entry accepted at edge N appears with valid_m_o=1 after edge N.
- Throughput: 1 per cycle while ready_m_i=1.
- A single ready_m_i low cycle is absorbed by the skid without loss or duplication. Order is strictly FIFO.
- Flush asserted at edge N: valid_m_o=0 and ready_e_o=1 after edge N.

## Configuration
- EX_MEM_STALL_CNT_EN defined: adds output stall_cnt_o (32 bits).
  - It increments each cycle in which valid_m_o=1 and ready_m_i=0, and saturates at 0xFFFF_FFFF.
  - It is cleared by rst_i only; flush_i does not clear it.
- Undefined: the port and the counter logic are absent.

## Structure
- Package pipe_pkg holds:
  - ex_mem_t packed struct of the payload fields, parametrised via package constants matching the defaults
  - skid_state_e enum (EMPTY, ONE, TWO)
- Sub-module pipe_skid_buf: a generic two-entry skid buffer over a WIDTH-bit payload with flush. ex_mem_stage instantiates it on ex_mem_t, then applies control squashing and the optional counter.

## Test plan
- Reset: assert rst_i mid-stream with two entries held -> all outputs 0, valid_m_o=0, ready_e_o=1 immediately.
- Streaming: 8 back-to-back entries (alu_result 1..8), ready_m_i=1 -> outputs 1..8 on consecutive cycles, 1-cycle latency.
- Back-pressure:
  - Drop ready_m_i for 1 cycle mid-stream -> ready_e_o falls the next cycle, no loss or duplication, order 1..8 preserved.
  - Hold ready_m_i low for 5 cycles -> exactly 2 entries held, then released in order.
- Flush: flush_i together with valid_e_i while in TWO -> EMPTY next cycle, valid_m_o=0, reg_write_m_o=0, mem_write_m_o=0, and the new input is dropped.
- Squash: entry with reg_write=1 and mem_write=1 drained, then idle -> both control outputs read 0 while the data outputs keep their last values.
- With EX_MEM_STALL_CNT_EN: 5 stall cycles -> stall_cnt_o=5; it stays 5 after a flush and returns to 0 after rst_i.
